// File: rtl/instr_register_pkg.sv
// Shared types for the instruction-register load arbiter: instruction fields,
// register addressing and the load/readback FSM encoding.
package instr_register_pkg;

  localparam int DEPTH_DEFAULT = 32;

  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} arb_state_t;

  // Division by zero is rejected at acceptance rather than stored.
  function automatic logic is_div0(opcode_t opc, operand_t op_b);
    return ((opc == DIV) || (opc == MOD)) && (op_b == '0);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: one-hot grant, the requester not granted
// last wins a tie; after reset requester 0 wins first.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  logic r_last;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) o_grant = r_last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (reset)                  r_last <= 1'b1;
    else if (o_grant != 2'b00)  r_last <= o_grant[1];
  end

endmodule

// File: rtl/instr_load_arbiter.sv
// Arbitrates two instruction loaders into the instruction register and streams
// the stored entries back out on request.
//   state | meaning
//   IDLE  | accepting loads, waiting for rd_start
//   READ  | driving read_pointer 0..count-1
//   DRAIN | collecting the last read word
//   DONE  | rd_done pulse, clear count and write pointer
module instr_load_arbiter
  import instr_register_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  opcode_t                req_opcode    [2],
  input  operand_t               req_operand_a [2],
  input  operand_t               req_operand_b [2],
  input  logic                   rd_start,
  output logic                   load_en,
  output address_t               write_pointer,
  output opcode_t                opcode,
  output operand_t               operand_a,
  output operand_t               operand_b,
  output address_t               read_pointer,
  input  instruction_t           instruction_word,
  output logic                   out_valid,
  output instruction_t           out_word,
  output address_t               out_index,
  output logic                   rd_done,
  output logic                   err_div0,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  arb_state_t       r_state, w_next;
  address_t         r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_can_grant, w_xfer, w_sel, w_div0, w_load, w_last_rd;
  logic [1:0]       w_req, w_grant;
  opcode_t          w_opc;
  operand_t         w_a, w_b;
  instruction_t     w_rd_word;

  assign w_can_grant = (r_state == IDLE) && (r_count < CNT_W'(DEPTH)) && !rd_start;
  assign w_req       = req_valid & {2{w_can_grant}};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  assign req_ready = w_grant;
  assign w_xfer    = |w_grant;
  assign w_sel     = w_grant[1];
  assign w_opc     = req_opcode[w_sel];
  assign w_a       = req_operand_a[w_sel];
  assign w_b       = req_operand_b[w_sel];
  assign w_div0    = is_div0(w_opc, w_b);
  assign w_load    = w_xfer && !w_div0;
  assign w_last_rd = (CNT_W'(r_rd_ptr) == (r_count - CNT_W'(1)));
  assign count     = r_count;

  // A load still in flight when readback starts has not reached the register yet.
  assign w_rd_word = (load_en && (write_pointer == r_rd_ptr)) ?
                     {opcode, operand_a, operand_b} : instruction_word;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (rd_start) w_next = (r_count == '0) ? DONE : READ;
      READ:    if (w_last_rd) w_next = DRAIN;
      DRAIN:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    read_pointer = (r_state == READ) ? r_rd_ptr : '0;
    rd_done      = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      load_en       <= 1'b0;
      err_div0      <= 1'b0;
      write_pointer <= '0;
      opcode        <= ZERO;
      operand_a     <= '0;
      operand_b     <= '0;
      out_valid     <= 1'b0;
      out_word      <= '0;
      out_index     <= '0;
    end else begin
      load_en  <= w_load;
      err_div0 <= w_xfer && w_div0;
      if (w_load) begin
        write_pointer <= r_wr_ptr;
        opcode        <= w_opc;
        operand_a     <= w_a;
        operand_b     <= w_b;
        r_wr_ptr      <= r_wr_ptr + address_t'(1);
        r_count       <= r_count + CNT_W'(1);
      end else if (r_state == DONE) begin
        r_wr_ptr <= '0;
        r_count  <= '0;
      end
      r_rd_ptr  <= (r_state == READ) ? r_rd_ptr + address_t'(1) : '0;
      out_valid <= (r_state == READ);
      if (r_state == READ) begin
        out_word  <= w_rd_word;
        out_index <= r_rd_ptr;
      end
    end
  end

endmodule

// File: tb/tb_instr_load_arbiter.sv
// Bench for instr_load_arbiter: directed table, multi-cycle corner sequences and
// a randomized run against a transaction-level schedule model.
module tb_instr_load_arbiter;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready;
  opcode_t      req_opcode    [2];
  operand_t     req_operand_a [2];
  operand_t     req_operand_b [2];
  logic         rd_start, load_en, out_valid, rd_done, err_div0;
  address_t     write_pointer, read_pointer, out_index;
  opcode_t      opcode;
  operand_t     operand_a, operand_b;
  instruction_t instruction_word, out_word;
  logic [5:0]   count;

  instruction_t mem [32];
  instruction_t exp_words [32];
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] valid;
    logic       rd;
    opcode_t    opc1;
    int         a1;
    int         b1;
    logic [1:0] exp_ready;
    logic       exp_load;
    int         exp_wp;
    opcode_t    exp_opc;
    logic       exp_err;
    int         exp_count;
  } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  instr_load_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
    .rd_start(rd_start), .load_en(load_en), .write_pointer(write_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .read_pointer(read_pointer), .instruction_word(instruction_word),
    .out_valid(out_valid), .out_word(out_word), .out_index(out_index),
    .rd_done(rd_done), .err_div0(err_div0), .count(count)
  );

  // External instruction register: synchronous write, combinational read.
  always @(posedge clk) if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b};
  assign instruction_word = mem[read_pointer];

  function automatic instruction_t mk(opcode_t o, int a, int b);
    instruction_t w;
    w.opc = o; w.op_a = a; w.op_b = b;
    return w;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input instruction_t w);
    req_opcode[k] = w.opc; req_operand_a[k] = w.op_a; req_operand_b[k] = w.op_b;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 2'b00; rd_start = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Called at the start of the cycle after rd_start was accepted with n>0 entries.
  task automatic readback(input int n);
    for (int i = 0; i < n; i++) begin
      rd_start = 1'b0; req_valid = 2'b11;
      chk("rb_out_valid", out_valid, i > 0);
      if (i > 0) begin
        chk($sformatf("rb_out_index[%0d]", i - 1), out_index, i - 1);
        chk($sformatf("rb_out_word[%0d]", i - 1), out_word, exp_words[i - 1]);
      end
      #1;
      chk($sformatf("rb_read_pointer[%0d]", i), read_pointer, i);
      chk("rb_ready_busy", req_ready, 2'b00);
      tick();
    end
    chk("rb_drain_valid", out_valid, 1'b1);
    chk("rb_drain_index", out_index, n - 1);
    chk("rb_drain_word", out_word, exp_words[n - 1]);
    chk("rb_drain_no_done", rd_done, 1'b0);
    rd_start = 1'b1;
    #1;
    chk("rb_drain_rp", read_pointer, 0);
    chk("rb_drain_ready", req_ready, 2'b00);
    tick();
    chk("rb_done_pulse", rd_done, 1'b1);
    chk("rb_done_no_valid", out_valid, 1'b0);
    rd_start = 1'b0;
    #1;
    chk("rb_done_ready", req_ready, 2'b00);
    tick();
    req_valid = 2'b00;
    chk("rb_after_done", rd_done, 1'b0);
    chk("rb_count_cleared", count, 0);
    chk("rb_after_valid", out_valid, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    set_req(0, mk(ADD, 5, 3)); set_req(1, mk(SUB, 9, 4));
    do_reset();

    // Reset state
    chk("rst_load_en", load_en, 1'b0);
    chk("rst_write_pointer", write_pointer, 0);
    chk("rst_opcode", opcode, ZERO);
    chk("rst_operands", {operand_a, operand_b}, 64'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_word", out_word, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_rd_done", rd_done, 1'b0);
    chk("rst_err_div0", err_div0, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_read_pointer", read_pointer, 0);

    // Round-robin, div-by-zero rejection, rd_start priority
    tbl[0] = '{2'b11, 1'b0, SUB,   9, 4, 2'b01, 1'b0, 0, ZERO,  1'b0, 0};
    tbl[1] = '{2'b11, 1'b0, SUB,   9, 4, 2'b10, 1'b1, 0, ADD,   1'b0, 1};
    tbl[2] = '{2'b11, 1'b0, SUB,   9, 4, 2'b01, 1'b1, 1, SUB,   1'b0, 2};
    tbl[3] = '{2'b11, 1'b0, SUB,   9, 4, 2'b10, 1'b1, 2, ADD,   1'b0, 3};
    tbl[4] = '{2'b10, 1'b0, DIV,   7, 0, 2'b10, 1'b1, 3, SUB,   1'b0, 4};
    tbl[5] = '{2'b00, 1'b0, DIV,   7, 0, 2'b00, 1'b0, 0, ZERO,  1'b1, 4};
    tbl[6] = '{2'b10, 1'b0, PASSA, 7, 0, 2'b10, 1'b0, 0, ZERO,  1'b0, 4};
    tbl[7] = '{2'b00, 1'b0, PASSA, 7, 0, 2'b00, 1'b1, 4, PASSA, 1'b0, 5};
    tbl[8] = '{2'b01, 1'b1, PASSA, 7, 0, 2'b00, 1'b0, 0, ZERO,  1'b0, 5};
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("tbl%0d_load_en", i), load_en, tbl[i].exp_load);
      if (tbl[i].exp_load) begin
        chk($sformatf("tbl%0d_write_pointer", i), write_pointer, tbl[i].exp_wp);
        chk($sformatf("tbl%0d_opcode", i), opcode, tbl[i].exp_opc);
      end
      chk($sformatf("tbl%0d_err_div0", i), err_div0, tbl[i].exp_err);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_count);
      set_req(0, mk(ADD, 5, 3));
      set_req(1, mk(tbl[i].opc1, tbl[i].a1, tbl[i].b1));
      req_valid = tbl[i].valid; rd_start = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].exp_ready);
      tick();
    end
    exp_words[0] = mk(ADD, 5, 3); exp_words[1] = mk(SUB, 9, 4);
    exp_words[2] = mk(ADD, 5, 3); exp_words[3] = mk(SUB, 9, 4);
    exp_words[4] = mk(PASSA, 7, 0);
    readback(5);

    // Readback with nothing loaded
    rd_start = 1'b1; req_valid = 2'b01;
    #1;
    chk("empty_rd_no_grant", req_ready, 2'b00);
    tick();
    rd_start = 1'b0; req_valid = 2'b00;
    chk("empty_rd_done", rd_done, 1'b1);
    chk("empty_rd_no_valid", out_valid, 1'b0);
    tick();
    chk("empty_rd_done_once", rd_done, 1'b0);
    chk("empty_rd_no_valid2", out_valid, 1'b0);

    // Three loads, rd_start while the last load_en is still pending
    for (int i = 0; i < 3; i++) begin
      exp_words[i] = mk(MULT, 100 + i, -i);
      set_req(0, exp_words[i]); req_valid = 2'b01;
      #1;
      chk("three_ready", req_ready, 2'b01);
      tick();
    end
    req_valid = 2'b00; rd_start = 1'b1;
    chk("three_pending_load", load_en, 1'b1);
    chk("three_pending_wp", write_pointer, 2);
    chk("three_count", count, 3);
    tick();
    readback(3);

    // Fill to DEPTH, then further requests are refused
    do_reset();
    for (int i = 0; i < 32; i++) begin
      exp_words[i] = mk(PASSB, i, 3 * i);
      if (i > 0) begin
        chk("full_load_en", load_en, 1'b1);
        chk("full_wp", write_pointer, i - 1);
      end
      set_req(0, exp_words[i]); req_valid = 2'b01;
      #1;
      chk($sformatf("full_ready%0d", i), req_ready, 2'b01);
      tick();
    end
    chk("full_last_load", load_en, 1'b1);
    chk("full_last_wp", write_pointer, 31);
    chk("full_count", count, 32);
    req_valid = 2'b11;
    #1;
    chk("full_no_ready", req_ready, 2'b00);
    tick();
    chk("full_no_33rd_load", load_en, 1'b0);
    chk("full_count_held", count, 32);
    #1;
    chk("full_no_ready2", req_ready, 2'b00);
    req_valid = 2'b00; rd_start = 1'b1;
    tick();
    readback(32);

    // Reset while READ is at index 1
    for (int i = 0; i < 3; i++) begin
      set_req(1, mk(MOD, 20 + i, i + 1)); req_valid = 2'b10;
      tick();
    end
    req_valid = 2'b00; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    #1;
    chk("mid_rp1", read_pointer, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rp0", read_pointer, 0);
    chk("mid_out_valid", out_valid, 1'b0);
    chk("mid_rd_done", rd_done, 1'b0);
    chk("mid_count", count, 0);
    chk("mid_load_en", load_en, 1'b0);
    chk("mid_opcode", opcode, ZERO);
    chk("mid_out_word", out_word, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_done", rd_done, 1'b0);
      chk("mid_no_valid", out_valid, 1'b0);
    end
    set_req(1, mk(PASSA, 42, 1)); req_valid = 2'b10;
    #1;
    chk("mid_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("mid_reload_en", load_en, 1'b1);
    chk("mid_reload_wp", write_pointer, 0);

    // Randomized run against a schedule-based model
    do_reset();
    begin : rnd
      instruction_t loaded[$];
      address_t     exp_rp [int];
      instruction_t exp_ow [int];
      int           exp_oi [int];
      instruction_t f [2];
      instruction_t exp_ins;
      address_t     exp_wp;
      logic [1:0]   v, exp_ready;
      bit           rs, exp_le, exp_err;
      int           busy_end, done_cyc, last_w, g, n;
      busy_end = -1; done_cyc = -1; last_w = 1; exp_le = 0; exp_err = 0; exp_wp = '0;
      exp_ins = '0;
      for (int c = 0; c < 3000; c++) begin
        chk("rnd_load_en", load_en, exp_le);
        if (exp_le) begin
          chk("rnd_write_pointer", write_pointer, exp_wp);
          chk("rnd_fields", {opcode, operand_a, operand_b}, exp_ins);
        end
        chk("rnd_err_div0", err_div0, exp_err);
        chk("rnd_out_valid", out_valid, exp_ow.exists(c));
        if (exp_ow.exists(c)) begin
          chk("rnd_out_index", out_index, exp_oi[c]);
          chk("rnd_out_word", out_word, exp_ow[c]);
        end
        chk("rnd_rd_done", rd_done, c == done_cyc);
        chk("rnd_count", count, loaded.size());
        if (c == done_cyc) loaded.delete();

        for (int k = 0; k < 2; k++) begin
          f[k].opc  = opcode_t'($urandom_range(0, 7));
          f[k].op_a = $urandom;
          f[k].op_b = ($urandom_range(0, 3) == 0) ? 0 : $urandom;
          set_req(k, f[k]);
        end
        v = 2'($urandom_range(0, 3));
        rs = ($urandom_range(0, 40) == 0);
        req_valid = v; rd_start = rs;
        #1;
        g = -1;
        if (c > busy_end && !rs && loaded.size() < 32) begin
          if (v == 2'b11)      g = 1 - last_w;
          else if (v == 2'b01) g = 0;
          else if (v == 2'b10) g = 1;
        end
        exp_ready = (g < 0) ? 2'b00 : (g == 0 ? 2'b01 : 2'b10);
        chk("rnd_req_ready", req_ready, exp_ready);
        chk("rnd_read_pointer", read_pointer, exp_rp.exists(c) ? exp_rp[c] : 5'd0);

        exp_le = 0; exp_err = 0;
        if (g >= 0) begin
          last_w = g;
          if ((f[g].opc == DIV || f[g].opc == MOD) && f[g].op_b == 0) exp_err = 1;
          else begin
            exp_le = 1; exp_wp = address_t'(loaded.size()); exp_ins = f[g];
            loaded.push_back(f[g]);
          end
        end
        if (c > busy_end && rs) begin
          n = loaded.size();
          for (int i = 0; i < n; i++) begin
            exp_rp[c + 1 + i] = address_t'(i);
            exp_oi[c + 2 + i] = i;
            exp_ow[c + 2 + i] = loaded[i];
          end
          done_cyc = (n > 0) ? c + n + 2 : c + 1;
          busy_end = done_cyc;
        end
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
